// File: rtl/lane_tx_pkg.sv
// Shared types, PRBS7 constants and the word-to-lane mapping of the DDR lane transmitter.
// Used by lane_serializer_tx and by receive-side bench models.
package lane_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAIN = 2'd1,
        DATA  = 2'd2
    } tx_state_e;

    // Widest lane count the mapping helper supports; narrower words are zero-extended.
    localparam int LANE_MAX = 32;
    localparam int WORD_MAX = 2 * LANE_MAX;

    // PRBS7, x^7 + x^6 + 1: feedback taps on state bits 6 and 5.
    localparam logic [6:0] PRBS7_TAPS = 7'h60;
    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    // Rise/fall pair {fall, rise} carried by one lane of a sample word.
    function automatic logic [1:0] word_to_lanes(input logic [WORD_MAX-1:0] word, input int lane);
        return {word[2*lane+1], word[2*lane]};
    endfunction

    // One PRBS7 shift; the newly generated bit lands in bit 0.
    function automatic logic [6:0] prbs7_step(input logic [6:0] state);
        return {state[5:0], ^(state & PRBS7_TAPS)};
    endfunction

endpackage

// File: rtl/lane_tx_fifo2.sv
// Two-entry word buffer with push, pop and synchronous flush.
// The owner never pushes when full nor pops when empty.
module lane_tx_fifo2
    import lane_tx_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         dco_clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) r_wr_ptr <= ~r_wr_ptr;
            if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; r_count alone decides which entries are meaningful.
    always_ff @(posedge dco_clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/lane_serializer_tx.sv
// DDR lane transmitter: preamble, buffered data and idle fill, split into per-lane rise/fall bits.
// Define LANE_TX_PRBS_EN to replace the fixed training word with a PRBS7 preamble.
module lane_serializer_tx
    import lane_tx_pkg::*;
#(
    parameter int                 LANES         = 8,
    parameter int                 TRAIN_WORDS   = 16,
    parameter logic [2*LANES-1:0] TRAIN_PATTERN = 16'hA5F0,
    parameter logic [2*LANES-1:0] IDLE_PATTERN  = 16'h0000,
    parameter int                 UCNT_W        = 16
) (
    input  logic               dco_clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               retrain,
    input  logic [2*LANES-1:0] s_word,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [LANES-1:0]   bit_rise,
    output logic [LANES-1:0]   bit_fall,
    output logic               frame,
    output logic               training,
    output logic               tx_active,
    output logic [UCNT_W-1:0]  underflow_cnt
);

    localparam int W     = 2 * LANES;
    localparam int CNT_W = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;
    localparam logic [CNT_W-1:0] TRAIN_LOAD = CNT_W'(TRAIN_WORDS - 1);

    tx_state_e         r_state, w_next_state;
    logic [CNT_W-1:0]  r_train_cnt, w_train_cnt_nxt;
    logic [LANES-1:0]  r_rise, r_fall, w_rise_nxt, w_fall_nxt;
    logic              r_frame, r_training;
    logic [UCNT_W-1:0] r_underflow_cnt;
    logic [W-1:0]      w_head, w_word_nxt, w_train_word;
    logic [1:0]        w_count;
    logic              w_push, w_pop, w_underflow;

    assign s_ready = (w_count != 2'd2) && (r_state != IDLE);
    assign w_push  = s_valid && s_ready;

    lane_tx_fifo2 #(.W(W)) u_fifo (
        .dco_clk (dco_clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (!enable),
        .i_wdata (s_word),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state    = r_state;
        w_train_cnt_nxt = r_train_cnt;
        if (!enable) begin
            w_next_state = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_next_state    = TRAIN;
                    w_train_cnt_nxt = TRAIN_LOAD;
                end
                TRAIN: begin
                    if (retrain)                 w_train_cnt_nxt = TRAIN_LOAD;
                    else if (r_train_cnt == '0)  w_next_state    = DATA;
                    else                         w_train_cnt_nxt = r_train_cnt - CNT_W'(1);
                end
                DATA: begin
                    if (retrain) begin
                        w_next_state    = TRAIN;
                        w_train_cnt_nxt = TRAIN_LOAD;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // The output register always shows the word belonging to the state being entered.
    always_comb begin
        w_pop       = 1'b0;
        w_underflow = 1'b0;
        w_word_nxt  = '0;
        case (w_next_state)
            TRAIN: w_word_nxt = w_train_word;
            DATA: begin
                if (w_count != 2'd0) begin
                    w_pop      = 1'b1;
                    w_word_nxt = w_head;
                end else begin
                    w_word_nxt  = IDLE_PATTERN;
                    w_underflow = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        for (int i = 0; i < LANES; i++) begin
            {w_fall_nxt[i], w_rise_nxt[i]} = word_to_lanes(WORD_MAX'(w_word_nxt), i);
        end
    end

`ifdef LANE_TX_PRBS_EN
    logic [6:0] r_lfsr, w_lfsr_nxt;

    // Reseed whenever a preamble (re)starts, otherwise continue the sequence.
    always_comb begin
        logic [6:0] v_state;
        w_train_word = '0;
        v_state      = (r_state != TRAIN || retrain) ? PRBS7_SEED : r_lfsr;
        for (int j = 0; j < W; j++) begin
            v_state         = prbs7_step(v_state);
            w_train_word[j] = v_state[0];
        end
        w_lfsr_nxt = v_state;
    end

    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n)                      r_lfsr <= PRBS7_SEED;
        else if (w_next_state == TRAIN)  r_lfsr <= w_lfsr_nxt;
    end
`else
    assign w_train_word = TRAIN_PATTERN;
`endif

    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_train_cnt     <= '0;
            r_rise          <= '0;
            r_fall          <= '0;
            r_frame         <= 1'b0;
            r_training      <= 1'b0;
            r_underflow_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_train_cnt <= w_train_cnt_nxt;
            r_rise      <= w_rise_nxt;
            r_fall      <= w_fall_nxt;
            r_frame     <= (w_next_state == IDLE) ? 1'b0 : ~r_frame;
            r_training  <= (w_next_state == TRAIN);
            if (w_underflow && r_underflow_cnt != '1)
                r_underflow_cnt <= r_underflow_cnt + UCNT_W'(1);
        end
    end

    assign bit_rise      = r_rise;
    assign bit_fall      = r_fall;
    assign frame         = r_frame;
    assign training      = r_training;
    assign tx_active     = (r_state != IDLE);
    assign underflow_cnt = r_underflow_cnt;

endmodule
